// File: rtl/pilots_remove_axis.sv
// RX pilot/null removal after the FFT: data bins forwarded in order, pilots to a sideband port.
// Latency 1 cycle on both ports. Data bins stall on m_axis_tready; null/pilot bins never stall.
// Optional pilot sign checker enabled by defining PILOT_SIGN_CHECK_EN.
module pilots_remove_axis #(
    parameter int          NFFT       = 64,
    parameter logic [63:0] PILOT_MASK = 64'h0200_0800_0020_0080,
    parameter logic [63:0] NULL_MASK  = 64'h0000_003F_F800_0001
`ifdef PILOT_SIGN_CHECK_EN
    ,
    parameter logic [3:0]  PILOT_POL  = 4'b0000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_slot_last,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_slot_last,
    output logic        m_pilot_valid,
    output logic [31:0] m_pilot_data,
    output logic [1:0]  m_pilot_idx,
    output logic        err_tlast_unexp,
    output logic        err_tlast_miss,
    output logic [15:0] pilot_err_cnt
);
    localparam int KW = $clog2(NFFT);

    // Highest bin index that is neither null nor pilot: it carries m_axis_tlast.
    function automatic int last_data_bin(input logic [63:0] nm, input logic [63:0] pm);
        int r;
        r = 0;
        for (int i = 0; i < NFFT; i++)
            if (!nm[i] && !pm[i]) r = i;
        return r;
    endfunction

    localparam logic [KW-1:0] K_LAST_DATA = KW'(last_data_bin(NULL_MASK, PILOT_MASK));
    localparam logic [KW-1:0] K_END       = KW'(NFFT - 1);

    logic [KW-1:0] k_q, k_d;
    logic [1:0]    pidx_q, pidx_d;
    logic          is_null, is_pilot, is_data;
    logic          acc, data_acc, pil_acc, at_end, sym_end;

    logic          m_vld_q, m_last_q, m_slot_q;
    logic [31:0]   m_dat_q;
    logic          p_vld_q;
    logic [31:0]   p_dat_q;
    logic [1:0]    p_idx_q;
    logic          e_unexp_q, e_miss_q;

    assign is_null  = NULL_MASK[k_q];
    assign is_pilot = ~is_null & PILOT_MASK[k_q];
    assign is_data  = ~is_null & ~is_pilot;

    assign s_axis_tready = is_data ? (~m_vld_q | m_axis_tready) : 1'b1;
    assign acc      = s_axis_tvalid & s_axis_tready;
    assign data_acc = acc & is_data;
    assign pil_acc  = acc & is_pilot;
    assign at_end   = (k_q == K_END);
    // An early tlast also closes the symbol so the next bin restarts at k=0.
    assign sym_end  = acc & (s_axis_tlast | at_end);

    always_comb begin
        k_d    = k_q;
        pidx_d = pidx_q;
        if (acc) begin
            k_d = sym_end ? '0 : k_q + 1'b1;
            if (sym_end)      pidx_d = 2'd0;
            else if (is_pilot) pidx_d = pidx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            pidx_q    <= 2'd0;
            m_vld_q   <= 1'b0;
            m_dat_q   <= 32'd0;
            m_last_q  <= 1'b0;
            m_slot_q  <= 1'b0;
            p_vld_q   <= 1'b0;
            p_dat_q   <= 32'd0;
            p_idx_q   <= 2'd0;
            e_unexp_q <= 1'b0;
            e_miss_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            pidx_q <= pidx_d;
            if (data_acc) begin
                m_vld_q  <= 1'b1;
                m_dat_q  <= s_axis_tdata;
                m_last_q <= (k_q == K_LAST_DATA);
                m_slot_q <= (k_q == K_LAST_DATA) & s_axis_tlast & s_slot_last;
            end else if (m_axis_tready) begin
                m_vld_q <= 1'b0;
            end
            p_vld_q <= pil_acc;
            if (pil_acc) begin
                p_dat_q <= s_axis_tdata;
                p_idx_q <= pidx_q;
            end
            e_unexp_q <= acc & s_axis_tlast & ~at_end;
            e_miss_q  <= acc & at_end & ~s_axis_tlast;
        end
    end

    assign m_axis_tvalid    = m_vld_q;
    assign m_axis_tdata     = m_dat_q;
    assign m_axis_tlast     = m_vld_q & m_last_q;
    assign m_axis_slot_last = m_vld_q & m_slot_q;
    assign m_pilot_valid    = p_vld_q;
    assign m_pilot_data     = p_dat_q;
    assign m_pilot_idx      = p_idx_q;
    assign err_tlast_unexp  = e_unexp_q;
    assign err_tlast_miss   = e_miss_q;

`ifdef PILOT_SIGN_CHECK_EN
    logic [15:0] perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (pil_acc && (s_axis_tdata[31] != PILOT_POL[pidx_q]) && (perr_q != 16'hFFFF))
            perr_d = perr_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) perr_q <= 16'd0;
        else      perr_q <= perr_d;
    end

    assign pilot_err_cnt = perr_q;
`else
    assign pilot_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pilots_remove_axis.sv
// Scoreboard bench for pilots_remove_axis: driver pushes expected beats, monitors pop and compare.
module tb_pilots_remove_axis;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tlast = 1'b0;
    logic        s_slot_last = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_slot_last;
    logic        m_pilot_valid;
    logic [31:0] m_pilot_data;
    logic [1:0]  m_pilot_idx;
    logic        err_tlast_unexp;
    logic        err_tlast_miss;
    logic [15:0] pilot_err_cnt;

    pilots_remove_axis dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_slot_last(s_slot_last),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_slot_last(m_axis_slot_last),
        .m_pilot_valid(m_pilot_valid), .m_pilot_data(m_pilot_data), .m_pilot_idx(m_pilot_idx),
        .err_tlast_unexp(err_tlast_unexp), .err_tlast_miss(err_tlast_miss),
        .pilot_err_cnt(pilot_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];   // {slot_last, tlast, tdata}
    logic [33:0] pexp_q[$];  // {idx, data}
    int kk = 0, pidx = 0;
    int exp_unexp = 0, exp_miss = 0, obs_unexp = 0, obs_miss = 0, exp_perr = 0;
    int n_out = 0, n_pil = 0;
    int rdy_mode = 0;        // 0 always ready, 1 random, 2 never ready

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'b1;
        endcase
    end

    // Monitors sample 2 ns before the rising edge, when all inputs and outputs are settled.
    always @(negedge clk) begin
        logic [33:0] e;
        #3;
        if (m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_data_out", {32'd0, m_axis_tdata}, 64'hDEAD);
            else begin
                e = exp_q.pop_front();
                check("data_out", {30'd0, m_axis_slot_last, m_axis_tlast, m_axis_tdata}, {30'd0, e});
            end
        end
        if (m_pilot_valid) begin
            n_pil++;
            if (pexp_q.size() == 0) check("unexpected_pilot", {32'd0, m_pilot_data}, 64'hDEAD);
            else begin
                e = pexp_q.pop_front();
                check("pilot_out", {30'd0, m_pilot_idx, m_pilot_data}, {30'd0, e});
            end
        end
        if (err_tlast_unexp) obs_unexp++;
        if (err_tlast_miss) obs_miss++;
    end

    function automatic bit is_null_bin(input int k);
        return (k == 0) || (k >= 27 && k <= 37);
    endfunction
    function automatic bit is_pilot_bin(input int k);
        return (k == 7) || (k == 21) || (k == 43) || (k == 57);
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit l, input bit sl);
        bit acc = 1'b0;
        int n = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_slot_last = sl;
        while (!acc) begin
            #4;
            acc = s_axis_tready;
            @(posedge clk);
            if (!acc) begin
                n++;
                if (n > 1000) begin
                    check("input_timeout", 64'd0, 64'd1);
                    return;
                end
                @(negedge clk);
            end
        end
        if (is_pilot_bin(kk)) begin
            pexp_q.push_back({2'(pidx), d});
            if (d[31]) exp_perr++;
            pidx++;
        end else if (!is_null_bin(kk)) begin
            exp_q.push_back({sl & l & (kk == 63), kk == 63, d});
        end
        if (l && kk != 63) exp_unexp++;
        if (!l && kk == 63) exp_miss++;
        if (l || kk == 63) begin kk = 0; pidx = 0; end
        else kk++;
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_slot_last = 1'b0;
    endtask

    // Bins 0..stop_k; tlast on stop_k if lst. sgn puts +/- full-scale I on the pilots.
    task automatic send_frame(input int stop_k, input bit lst, input bit sl, input bit sgn);
        logic [31:0] d;
        for (int k = 0; k <= stop_k; k++) begin
            d = 32'(k);
            if (sgn && (k == 7 || k == 43)) d = {16'h7FFF, 16'(k)};
            if (sgn && (k == 21 || k == 57)) d = {16'h8001, 16'(k)};
            send_beat(d, lst && (k == stop_k), sl);
        end
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while ((exp_q.size() != 0 || pexp_q.size() != 0) && n < 500) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        check("drain_queues_empty", 64'(exp_q.size() + pexp_q.size()), 64'd0);
    endtask

    initial begin
        int o0, p0, perr_req;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_pilot_valid", 64'(m_pilot_valid), 64'd0);
        check("reset_errs", {62'd0, err_tlast_unexp, err_tlast_miss}, 64'd0);
        check("reset_pilot_err_cnt", 64'(pilot_err_cnt), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Basic frame, full throughput
        o0 = n_out; p0 = n_pil;
        send_frame(63, 1'b1, 1'b0, 1'b0);
        drain();
        check("t1_data_count", 64'(n_out - o0), 64'd48);
        check("t1_pilot_count", 64'(n_pil - p0), 64'd4);

        // Random downstream backpressure
        rdy_mode = 1;
        o0 = n_out;
        send_frame(63, 1'b1, 1'b0, 1'b0);
        drain();
        rdy_mode = 0;
        check("t2_data_count", 64'(n_out - o0), 64'd48);

        // Slot-last marker on second frame only
        send_frame(63, 1'b1, 1'b0, 1'b0);
        send_frame(63, 1'b1, 1'b1, 1'b0);
        drain();

        // Early tlast at k=40, then a clean frame
        send_frame(40, 1'b1, 1'b0, 1'b0);
        send_frame(63, 1'b1, 1'b0, 1'b0);
        drain();
        check("t4_unexp_pulses", 64'(obs_unexp), 64'd1);

        // Missing tlast at k=63, then a clean frame
        send_frame(63, 1'b0, 1'b0, 1'b0);
        send_frame(63, 1'b1, 1'b0, 1'b0);
        drain();
        check("miss_pulses", 64'(obs_miss), 64'd1);

        // Reset at k=30 while the output register holds bin 26
        send_frame(26, 1'b0, 1'b0, 1'b0);
        rdy_mode = 2;
        for (int k = 27; k <= 30; k++) send_beat(32'(k), 1'b0, 1'b0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        check("t5_held_valid", 64'(m_axis_tvalid), 64'd1);
        rst = 1'b0;
        #1;
        check("t5_reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_reset_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("t5_reset_pilot_err_cnt", 64'(pilot_err_cnt), 64'd0);
        exp_q.delete(); pexp_q.delete();
        kk = 0; pidx = 0; exp_perr = 0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        o0 = n_out;
        send_frame(63, 1'b1, 1'b0, 1'b0);
        drain();
        check("t5_data_count", 64'(n_out - o0), 64'd48);

        // Pilot sign pattern: two of four pilots negative per frame
        send_frame(63, 1'b1, 1'b0, 1'b1);
        send_frame(63, 1'b1, 1'b0, 1'b1);
        drain();
`ifdef PILOT_SIGN_CHECK_EN
        perr_req = 4;
`else
        perr_req = 0;
`endif
        if (exp_perr != 4) check("t6_model_sign_count", 64'(exp_perr), 64'd4);
        check("t6_pilot_err_cnt", 64'(pilot_err_cnt), 64'(perr_req));
        check("total_unexp", 64'(obs_unexp), 64'(exp_unexp));
        check("total_miss", 64'(obs_miss), 64'(exp_miss));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule
